trail_writer: RTL and testbench
===============================

Name: trail_writer

Overview:
- Producer side of the two-bit-plane line-memory pair (plane 1 = lsb, plane 2 = msb) that the shading block consumes.
- Pixel code = {msb, lsb}: 00 unshaded, 01 don't know, 10 red line, 11 border.
- Accepts pixel-write requests (x, y, code) over a valid/ready handshake and updates one pixel per request by read-modify-write of both planes.
- Provides a full-frame clear sweep that zeroes both planes before a new drawing.

Parameters:
- COLS, 800, pixels per row; width of the plane row words.
- ROWS, 600, rows per plane; the clear sweep covers rows 0..ROWS-1.
- RD_LAT, 1, plane memory read latency in cycles, from r_addr to r_data valid; minimum 1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- clear_n  in  1  asynchronous active-low reset.
- pt_valid  in  1  request valid.
- pt_ready  out  1  block can accept a request.
- pt_x  in  10  column, 0..COLS-1.
- pt_y  in  10  row, 0..ROWS-1.
- pt_code  in  2  code to write: bit1 goes to msb, bit0 goes to lsb.
- clr_start  in  1  single-cycle pulse that starts the full clear.
- busy  out  1  high in any state other than IDLE.
- drop_cnt  out  8  saturating count of dropped requests.
- r_addr1, r_addr2  out  17  row read address for plane 1 and plane 2; both always equal.
- r_data1, r_data2  in  [0:COLS-1]  row read data; bit index = column.
- w_en  out  1  write strobe for both planes.
- w_addr1, w_addr2  out  10  row write address; both always equal.
- w_data1, w_data2  out  [0:COLS-1]  row write data for lsb and msb.

Behaviour:
- Reset is asynchronous on clear_n low, with these values:
  - state = IDLE, pt_ready = 1, busy = 0, w_en = 0, drop_cnt = 0.
  - r_addr = 0, w_addr = 0, w_data = 0.
  - A reset during RD, WAIT, WR or CLR aborts the operation immediately. No partial write is issued, and w_en falls as soon as reset is asserted.
- States are IDLE, RD, WAIT, WR and CLR.
- IDLE:
  - pt_ready = 1.
  - A request is accepted on a posedge where pt_valid & pt_ready; x, y and code are registered at that edge.
  - If clr_start is high on the same edge as pt_valid, clr_start wins. The request is not accepted (pt_ready = 0 on the following cycle) and stays pending at the source.
  - An in-range accepted request moves to RD.
  - clr_start moves to CLR with the row counter at 0.
- Range check at acceptance:
  - A request with pt_x >= COLS or pt_y >= ROWS is accepted but dropped.
  - The block stays in IDLE, issues no memory access, and increments drop_cnt.
  - drop_cnt saturates at 255.
- RD:
  - Lasts 1 cycle.
  - r_addr1 = r_addr2 = y, zero-extended to 17 bits.
  - r_addr holds y through RD and WAIT.
- WAIT:
  - Lasts RD_LAT cycles.
  - On its last edge, r_data1 and r_data2 are captured into row registers.
- Modify step:
  - If the captured pixel at column x is 11 (border), the request is dropped: no write, drop_cnt increments.
  - Otherwise lsb[x] = code[0] and msb[x] = code[1]; every other bit is unchanged.
- WR:
  - Lasts 1 cycle.
  - w_en = 1, w_addr = y, w_data1 = modified lsb row, w_data2 = modified msb row.
  - For a dropped border pixel the state is still WR for one cycle, but w_en = 0.
  - Then IDLE.
- Latency with RD_LAT = 1:
  - Accept at edge k; RD during cycle k+1; WAIT during k+2; WR during k+3; IDLE with pt_ready = 1 from k+4.
  - Sustained throughput is 1 request per 4 cycles.
- CLR:
  - w_en = 1 every cycle, with w_addr = counter and w_data1 = w_data2 = 0.
  - The counter increments each cycle and runs 0..ROWS-1.
  - After the row ROWS-1 write the block returns to IDLE, so the sweep takes exactly ROWS cycles.
  - pt_ready = 0 throughout.
- clr_start outside IDLE is ignored (not queued).
- w_en = 0 in IDLE, RD and WAIT.
- busy = ~IDLE.

Test Plan:
1. Reset, then a request x=5, y=10, code=10 with the memory model returning all-zero rows:
   - r_addr = 10 in the cycle after accept.
   - w_en pulses exactly once at k+3 with w_addr = 10.
   - w_data2 has only bit 5 set; w_data1 = 0.
   - pt_ready returns at k+4.
2. Existing row holds 01 at bit 799, request x=799, y=599, code=10:
   - Bit 799 becomes msb = 1, lsb = 0.
   - All other bits of both rows are passed through unchanged.
3. Border pixel (11) at x=3, y=0, request code=00:
   - No w_en pulse.
   - drop_cnt goes 0 -> 1.
4. Out-of-range requests x=800 and y=600:
   - Both are accepted with no memory activity.
   - drop_cnt = 2.
   - pt_ready stays 1.
5. clr_start and pt_valid asserted on the same edge:
   - Exactly 600 consecutive w_en cycles with w_addr 0..599 and zero data.
   - The pending request is then accepted and written.
6. Reset during WAIT, and separately reset during CLR at row 300:
   - w_en is low immediately, with no further writes.
   - After reset: IDLE, pt_ready = 1, drop_cnt = 0.

Source files
------------

// File: rtl/trail_writer.sv
// trail_writer: read-modify-write of one pixel across the lsb/msb line-memory planes, plus a full-frame clear sweep.
// Latency: accept to write strobe is RD_LAT+2 cycles (IDLE again after RD_LAT+3); the clear sweep takes exactly ROWS cycles.
// Backpressure: pt_ready is high only in IDLE; clr_start beats a simultaneous request, which stays pending at the source.
module trail_writer #(
    parameter int COLS   = 800,
    parameter int ROWS   = 600,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            clear_n,
    input  logic            pt_valid,
    output logic            pt_ready,
    input  logic [9:0]      pt_x,
    input  logic [9:0]      pt_y,
    input  logic [1:0]      pt_code,
    input  logic            clr_start,
    output logic            busy,
    output logic [7:0]      drop_cnt,
    output logic [16:0]     r_addr1,
    output logic [16:0]     r_addr2,
    input  logic [0:COLS-1] r_data1,
    input  logic [0:COLS-1] r_data2,
    output logic            w_en,
    output logic [9:0]      w_addr1,
    output logic [9:0]      w_addr2,
    output logic [0:COLS-1] w_data1,
    output logic [0:COLS-1] w_data2
);

    localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_CLR
    } state_t;

    state_t          state_q, state_d;
    logic [9:0]      x_q;
    logic [9:0]      y_q;
    logic [1:0]      code_q;
    logic [WCW-1:0]  wait_cnt_q;
    logic [9:0]      clr_cnt_q;
    logic [0:COLS-1] lsb_q;
    logic [0:COLS-1] msb_q;
    logic [7:0]      drop_q, drop_d;

    logic            accept;
    logic            in_range;
    logic            wait_last;
    logic            clr_last;
    logic            border;
    logic            drop_inc;
    logic [0:COLS-1] lsb_mod;
    logic [0:COLS-1] msb_mod;

    // Request qualification: clr_start takes priority over a same-edge request.
    always_comb begin
        accept    = (state_q == S_IDLE) && pt_valid && !clr_start;
        in_range  = (32'(pt_x) < COLS) && (32'(pt_y) < ROWS);
        wait_last = (wait_cnt_q == WCW'(RD_LAT - 1));
        clr_last  = (clr_cnt_q == 10'(ROWS - 1));
        border    = lsb_q[x_q] & msb_q[x_q];
        drop_inc  = (accept && !in_range) || ((state_q == S_WR) && border);
        drop_d    = (drop_inc && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    end

    // Merge the requested code into the captured rows; x_q is always a valid column.
    always_comb begin
        lsb_mod       = lsb_q;
        msb_mod       = msb_q;
        lsb_mod[x_q]  = code_q[0];
        msb_mod[x_q]  = code_q[1];
    end

    // State register.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and outputs; outputs depend only on registered state so reset clears them at once.
    always_comb begin
        state_d  = state_q;
        pt_ready = 1'b0;
        busy     = 1'b1;
        w_en     = 1'b0;
        w_addr1  = y_q;
        w_data1  = '0;
        w_data2  = '0;
        case (state_q)
            S_IDLE: begin
                pt_ready = 1'b1;
                busy     = 1'b0;
                if (clr_start) begin
                    state_d = S_CLR;
                end else if (pt_valid && in_range) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_last) begin
                    state_d = S_WR;
                end
            end
            S_WR: begin
                w_en    = !border;
                w_data1 = lsb_mod;
                w_data2 = msb_mod;
                state_d = S_IDLE;
            end
            S_CLR: begin
                w_en    = 1'b1;
                w_addr1 = clr_cnt_q;
                if (clr_last) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        w_addr2 = w_addr1;
        r_addr1 = {7'd0, y_q};
        r_addr2 = r_addr1;
        drop_cnt = drop_q;
    end

    // Request capture, read-latency counter, row capture, clear counter and drop counter.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            x_q        <= '0;
            y_q        <= '0;
            code_q     <= '0;
            wait_cnt_q <= '0;
            clr_cnt_q  <= '0;
            lsb_q      <= '0;
            msb_q      <= '0;
            drop_q     <= '0;
        end else begin
            drop_q <= drop_d;
            case (state_q)
                S_IDLE: begin
                    if (clr_start) begin
                        clr_cnt_q <= '0;
                    end else if (accept && in_range) begin
                        x_q    <= pt_x;
                        y_q    <= pt_y;
                        code_q <= pt_code;
                    end
                end
                S_RD: begin
                    wait_cnt_q <= '0;
                end
                S_WAIT: begin
                    wait_cnt_q <= wait_cnt_q + WCW'(1);
                    if (wait_last) begin
                        lsb_q <= r_data1;
                        msb_q <= r_data2;
                    end
                end
                S_CLR: begin
                    clr_cnt_q <= clr_cnt_q + 10'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trail_writer.sv
// Bench for trail_writer: plane memories with one-cycle read latency, a request-level model, and per-cycle compare.
module tb_trail_writer;

    localparam int COLS = 800;
    localparam int ROWS = 600;
    localparam int LAT  = 1;

    logic            clk;
    logic            clear_n;
    logic            pt_valid;
    logic            pt_ready;
    logic [9:0]      pt_x;
    logic [9:0]      pt_y;
    logic [1:0]      pt_code;
    logic            clr_start;
    logic            busy;
    logic [7:0]      drop_cnt;
    logic [16:0]     r_addr1;
    logic [16:0]     r_addr2;
    logic [0:COLS-1] r_data1;
    logic [0:COLS-1] r_data2;
    logic            w_en;
    logic [9:0]      w_addr1;
    logic [9:0]      w_addr2;
    logic [0:COLS-1] w_data1;
    logic [0:COLS-1] w_data2;

    trail_writer #(.COLS(COLS), .ROWS(ROWS), .RD_LAT(LAT)) dut (
        .clk      (clk),
        .clear_n  (clear_n),
        .pt_valid (pt_valid),
        .pt_ready (pt_ready),
        .pt_x     (pt_x),
        .pt_y     (pt_y),
        .pt_code  (pt_code),
        .clr_start(clr_start),
        .busy     (busy),
        .drop_cnt (drop_cnt),
        .r_addr1  (r_addr1),
        .r_addr2  (r_addr2),
        .r_data1  (r_data1),
        .r_data2  (r_data2),
        .w_en     (w_en),
        .w_addr1  (w_addr1),
        .w_addr2  (w_addr2),
        .w_data1  (w_data1),
        .w_data2  (w_data2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [0:COLS-1] act, input logic [0:COLS-1] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got row differing from expected in %0d bits", name, $countones(act ^ exp));
        end
    endtask

    // Plane memories: one-cycle registered read, write on w_en.
    logic [0:COLS-1] mem1 [ROWS];
    logic [0:COLS-1] mem2 [ROWS];

    always @(posedge clk) begin
        r_data1 <= (r_addr1 < 17'(ROWS)) ? mem1[r_addr1[9:0]] : '0;
        r_data2 <= (r_addr2 < 17'(ROWS)) ? mem2[r_addr2[9:0]] : '0;
        if (w_en && (w_addr1 < 10'(ROWS))) begin
            mem1[w_addr1] = w_data1;
            mem2[w_addr2] = w_data2;
        end
    end

    // Request-level model: on each acceptance, schedule the periods in which the block is busy and what it writes.
    int              cyc, busy_until, wr_cyc, wr_y, rd_cyc, rd_y, clr_s, clr_e, drop_cyc, mdrop;
    logic [0:COLS-1] wr_d1, wr_d2;

    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            cyc        = 0;
            busy_until = -1;
            wr_cyc     = -1;
            wr_y       = 0;
            rd_cyc     = -10;
            rd_y       = 0;
            clr_s      = -1;
            clr_e      = -2;
            drop_cyc   = -1;
            mdrop      = 0;
        end else begin
            cyc = cyc + 1;
            if (cyc == drop_cyc && mdrop < 255) mdrop++;
            if (cyc - 1 > busy_until) begin
                if (clr_start) begin
                    clr_s      = cyc;
                    clr_e      = cyc + ROWS - 1;
                    busy_until = clr_e;
                end else if (pt_valid) begin
                    if (int'(pt_x) >= COLS || int'(pt_y) >= ROWS) begin
                        if (mdrop < 255) mdrop++;
                    end else begin
                        rd_cyc     = cyc;
                        rd_y       = int'(pt_y);
                        busy_until = cyc + LAT + 1;
                        if (mem1[pt_y][pt_x] && mem2[pt_y][pt_x]) begin
                            wr_cyc   = -1;
                            drop_cyc = cyc + LAT + 2;
                        end else begin
                            wr_cyc = cyc + LAT + 1;
                            wr_y   = int'(pt_y);
                            wr_d1  = mem1[pt_y];
                            wr_d2  = mem2[pt_y];
                            wr_d1[pt_x] = pt_code[0];
                            wr_d2[pt_x] = pt_code[1];
                        end
                    end
                end
            end
        end
    end

    // Per-cycle compare of every output against the model.
    int wen_total    = 0;
    int last_wen_cyc = -1;
    logic            exp_busy, in_clr, exp_wen;
    logic [0:COLS-1] zrow;

    always @(negedge clk) begin
        if (clear_n === 1'b1) begin
            exp_busy = (cyc <= busy_until);
            in_clr   = (cyc >= clr_s) && (cyc <= clr_e);
            exp_wen  = (cyc == wr_cyc) || in_clr;
            zrow     = '0;
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("pt_ready", 32'(pt_ready), 32'(!exp_busy));
            chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
            chk("w_en", 32'(w_en), 32'(exp_wen));
            if (exp_wen) begin
                chk("w_addr1", 32'(w_addr1), 32'(in_clr ? cyc - clr_s : wr_y));
                chk("w_addr2", 32'(w_addr2), 32'(in_clr ? cyc - clr_s : wr_y));
                chkw("w_data1", w_data1, in_clr ? zrow : wr_d1);
                chkw("w_data2", w_data2, in_clr ? zrow : wr_d2);
            end
            if (cyc >= rd_cyc && cyc <= rd_cyc + LAT) begin
                chk("r_addr1", 32'(r_addr1), 32'(rd_y));
                chk("r_addr2", 32'(r_addr2), 32'(rd_y));
            end
            if (w_en) begin
                wen_total++;
                last_wen_cyc = cyc;
            end
        end
    end

    task automatic send(input int x, input int y, input logic [1:0] c, input logic with_clr);
        bit acc;
        @(negedge clk);
        pt_x      = 10'(x);
        pt_y      = 10'(y);
        pt_code   = c;
        pt_valid  = 1'b1;
        clr_start = with_clr;
        acc       = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            acc = pt_ready && !clr_start;
            @(negedge clk);
            clr_start = 1'b0;
            if (acc) break;
        end
        pt_valid = 1'b0;
        chk("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 clear_n = 1'b0;
        #1;
        chk("rst_w_en", 32'(w_en), 32'd0);
        chk("rst_pt_ready", 32'(pt_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        chk("rst_hold_w_en", 32'(w_en), 32'd0);
        #2 clear_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [0:COLS-1] pat, e1, e2, zero_row;
    int              k, w0;
    bit              found;

    initial begin
        clear_n   = 1'b0;
        pt_valid  = 1'b0;
        pt_x      = '0;
        pt_y      = '0;
        pt_code   = '0;
        clr_start = 1'b0;
        zero_row  = '0;
        for (int r = 0; r < ROWS; r++) begin
            mem1[r] = '0;
            mem2[r] = '0;
        end
        for (int i = 0; i < COLS; i++) pat[i] = (i % 3 == 0);
        #1;
        chk("reset_pt_ready", 32'(pt_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_w_en", 32'(w_en), 32'd0);
        chk("reset_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("reset_r_addr1", 32'(r_addr1), 32'd0);
        chk("reset_w_addr1", 32'(w_addr1), 32'd0);
        chkw("reset_w_data1", w_data1, zero_row);
        chkw("reset_w_data2", w_data2, zero_row);
        repeat (3) @(negedge clk);
        #2 clear_n = 1'b1;

        // 1: plain write of code 10 at (5,10) into empty rows.
        w0 = wen_total;
        send(5, 10, 2'b10, 1'b0);
        k = cyc - 1;
        chk("t1_r_addr", 32'(r_addr1), 32'd10);
        repeat (3) @(negedge clk);
        chk("t1_ready_back", 32'(pt_ready), 32'd1);
        chk("t1_wen_offset", 32'(last_wen_cyc - k), 32'd3);
        chk("t1_wen_count", 32'(wen_total - w0), 32'd1);
        e2 = '0;
        e2[5] = 1'b1;
        chkw("t1_msb_row", mem2[10], e2);
        chkw("t1_lsb_row", mem1[10], zero_row);

        // 2: last column of last row, existing 01 becomes 10, neighbours untouched.
        mem1[599] = pat;
        mem2[599] = ~pat;
        mem1[599][799] = 1'b1;
        mem2[599][799] = 1'b0;
        e1 = mem1[599];
        e2 = mem2[599];
        e1[799] = 1'b0;
        e2[799] = 1'b1;
        send(799, 599, 2'b10, 1'b0);
        repeat (3) @(negedge clk);
        chkw("t2_lsb_row", mem1[599], e1);
        chkw("t2_msb_row", mem2[599], e2);

        // 3: border pixel is never overwritten.
        mem1[0][3] = 1'b1;
        mem2[0][3] = 1'b1;
        w0 = wen_total;
        send(3, 0, 2'b00, 1'b0);
        repeat (3) @(negedge clk);
        chk("t3_drop_cnt", 32'(drop_cnt), 32'd1);
        chk("t3_no_write", 32'(wen_total - w0), 32'd0);
        chk("t3_border_kept", 32'({mem2[0][3], mem1[0][3]}), 32'd3);

        // 4: out-of-range requests from a fresh reset.
        do_reset();
        w0 = wen_total;
        send(800, 0, 2'b01, 1'b0);
        chk("t4_ready_after_x", 32'(pt_ready), 32'd1);
        send(0, 600, 2'b01, 1'b0);
        chk("t4_drop_cnt", 32'(drop_cnt), 32'd2);
        chk("t4_ready", 32'(pt_ready), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_no_write", 32'(wen_total - w0), 32'd0);

        // 5: clear and request on the same edge; clear runs first, then the request lands.
        w0 = wen_total;
        send(7, 20, 2'b01, 1'b1);
        chk("t5_clear_writes", 32'(wen_total - w0), 32'd600);
        repeat (3) @(negedge clk);
        e1 = '0;
        e1[7] = 1'b1;
        chkw("t5_lsb_row", mem1[20], e1);
        chkw("t5_msb_row", mem2[20], zero_row);
        chkw("t5_row599_cleared", mem1[599], zero_row);
        chk("t5_border_cleared", 32'({mem2[0][3], mem1[0][3]}), 32'd0);

        // 6a: reset while waiting for read data aborts the write.
        w0 = wen_total;
        send(4, 4, 2'b10, 1'b0);
        @(negedge clk);
        #2 clear_n = 1'b0;
        #1 chk("t6a_w_en", 32'(w_en), 32'd0);
        repeat (2) @(negedge clk);
        chk("t6a_w_en_hold", 32'(w_en), 32'd0);
        #2 clear_n = 1'b1;
        @(negedge clk);
        chk("t6a_ready", 32'(pt_ready), 32'd1);
        chk("t6a_busy", 32'(busy), 32'd0);
        chk("t6a_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("t6a_no_write", 32'(wen_total - w0), 32'd0);
        chkw("t6a_row_untouched", mem2[4], zero_row);

        // 6b: reset during the clear sweep at row 300 stops it before that row.
        mem1[300] = pat;
        mem1[450] = pat;
        mem1[299] = pat;
        @(negedge clk);
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 700; i++) begin
            if (w_en && (w_addr1 == 10'd300)) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t6b_reach_row300", 32'(found), 32'd1);
        #2 clear_n = 1'b0;
        #1 chk("t6b_w_en", 32'(w_en), 32'd0);
        @(negedge clk);
        chk("t6b_w_en_hold", 32'(w_en), 32'd0);
        #2 clear_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6b_ready", 32'(pt_ready), 32'd1);
        chk("t6b_busy", 32'(busy), 32'd0);
        chk("t6b_drop_cnt", 32'(drop_cnt), 32'd0);
        chkw("t6b_row299_cleared", mem1[299], zero_row);
        chkw("t6b_row300_kept", mem1[300], pat);
        chkw("t6b_row450_kept", mem1[450], pat);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
